// File: rtl/axi_read_responder_pkg.sv
// Shared types for the AXI read responder: RRESP encodings and the responder FSM states.
package axi_read_responder_pkg;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_BURST
  } rspState_e;

endpackage

// File: rtl/axi_read_responder_ar.sv
// Request queue for accepted read addresses: a small synchronous FIFO with full/empty
// flags that honours a push and a pop in the same cycle.
module axi_ar_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] headData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign headData_o = entries_q[rdPtr_q];
  assign doPush     = push_i && !full_o;
  assign doPop      = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (doPush) begin
      entries_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI read-channel responder modelling main memory: queues burst reads, waits a fixed
// latency, then streams ARLEN+1 words from an internal array with RLAST on the final beat.
module axi_read_responder
  import axi_read_responder_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int LEN_WIDTH       = 8,
  parameter int MEM_INDEX_WIDTH = 10,
  parameter int READ_LATENCY    = 4,
  parameter int AR_DEPTH        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_WIDTH-1:0]        arid_i,
  input  logic [ADDR_WIDTH-1:0]      araddr_i,
  input  logic [LEN_WIDTH-1:0]       arlen_i,
  input  logic                       arvalid_i,
  output logic                       arready_o,
  output logic [ID_WIDTH-1:0]        rid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic [1:0]                 rresp_o,
  output logic                       rlast_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  input  logic                       load_en_i,
  input  logic [MEM_INDEX_WIDTH-1:0] load_index_i,
  input  logic [DATA_WIDTH-1:0]      load_data_i
);

  localparam int REQ_W = ID_WIDTH + MEM_INDEX_WIDTH + LEN_WIDTH;
  localparam int LAT_W = $clog2(READ_LATENCY) + 1;

  logic [DATA_WIDTH-1:0] mem [2**MEM_INDEX_WIDTH];

  logic                       qFull, qEmpty, qPop, qPush;
  logic [REQ_W-1:0]           qPushData, qHead;
  logic [ID_WIDTH-1:0]        headId;
  logic [MEM_INDEX_WIDTH-1:0] headIdx;
  logic [LEN_WIDTH-1:0]       headLen;
  logic                       unusedAddrBits;

  rspState_e                  state_q, state_d;
  logic [LAT_W-1:0]           latCnt_q, latCnt_d;
  logic [ID_WIDTH-1:0]        activeId_q, activeId_d;
  logic [MEM_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [MEM_INDEX_WIDTH-1:0] nextIdx;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       beatCnt_q, beatCnt_d;
  logic [ID_WIDTH-1:0]        rid_q, rid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       rlast_q, rlast_d;
  logic                       rvalid_q, rvalid_d;

  // Byte offset and aliased upper address bits do not select a word.
  assign unusedAddrBits = ^{araddr_i[ADDR_WIDTH-1:2+MEM_INDEX_WIDTH], araddr_i[1:0]};

  assign arready_o = !qFull && !rst;
  assign qPush     = arvalid_i && arready_o;
  assign qPushData = {arid_i, araddr_i[2 +: MEM_INDEX_WIDTH], arlen_i};
  assign {headId, headIdx, headLen} = qHead;

  axi_ar_queue #(
    .DEPTH (AR_DEPTH),
    .WIDTH (REQ_W)
  ) u_arQueue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (qPush),
    .pushData_i (qPushData),
    .pop_i      (qPop),
    .headData_o (qHead),
    .full_o     (qFull),
    .empty_o    (qEmpty)
  );

  assign nextIdx = idx_q + MEM_INDEX_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    latCnt_d   = latCnt_q;
    activeId_d = activeId_q;
    idx_d      = idx_q;
    len_d      = len_q;
    beatCnt_d  = beatCnt_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    qPop       = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (!qEmpty) begin
          qPop       = 1'b1;
          activeId_d = headId;
          idx_d      = headIdx;
          len_d      = headLen;
          latCnt_d   = LAT_W'(READ_LATENCY - 1);
          state_d    = RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        if (latCnt_q == '0) begin
          rvalid_d  = 1'b1;
          rdata_d   = mem[idx_q];
          rid_d     = activeId_q;
          rlast_d   = (len_q == '0);
          beatCnt_d = '0;
          state_d   = RSP_BURST;
        end else begin
          latCnt_d = latCnt_q - LAT_W'(1);
        end
      end
      RSP_BURST: begin
        if (rvalid_q && rready_i) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = RSP_IDLE;
          end else begin
            // Comparing beatCnt+1 against ARLEN keeps a full-length burst from wrapping to a false RLAST.
            idx_d     = nextIdx;
            rdata_d   = mem[nextIdx];
            beatCnt_d = beatCnt_q + LEN_WIDTH'(1);
            rlast_d   = ((beatCnt_q + LEN_WIDTH'(1)) == len_q);
          end
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RSP_IDLE;
      latCnt_q   <= '0;
      activeId_q <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      beatCnt_q  <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      latCnt_q   <= latCnt_d;
      activeId_q <= activeId_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      beatCnt_q  <= beatCnt_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Memory survives reset so preloaded contents stay valid across a reset.
  always_ff @(posedge clk) begin
    if (load_en_i) begin
      mem[load_index_i] <= load_data_i;
    end
  end

  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rlast_o  = rlast_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = RRESP_OKAY;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: latency, wrapping bursts, backpressure, queue full,
// preload race and asynchronous reset mid-burst, all against hand-computed expectations.
module tb_axi_read_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int LW  = 8;
  localparam int MIW = 10;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [IW-1:0]  arid_i;
  logic [AW-1:0]  araddr_i;
  logic [LW-1:0]  arlen_i;
  logic           arvalid_i;
  logic           arready_o;
  logic [IW-1:0]  rid_o;
  logic [DW-1:0]  rdata_o;
  logic [1:0]     rresp_o;
  logic           rlast_o;
  logic           rvalid_o;
  logic           rready_i;
  logic           load_en_i;
  logic [MIW-1:0] load_index_i;
  logic [DW-1:0]  load_data_i;

  int checkCount = 0;
  int failCount  = 0;

  logic [DW-1:0] expData [0:7];
  logic [IW-1:0] expId   [0:7];
  logic          expLast [0:7];

  localparam logic [DW-1:0] WORD_A = 32'h1111_AAAA;
  localparam logic [DW-1:0] WORD_B = 32'h2222_BBBB;
  localparam logic [DW-1:0] WORD_C = 32'h3333_CCCC;
  localparam logic [DW-1:0] WORD_D = 32'h4444_DDDD;

  axi_read_responder #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .ID_WIDTH        (IW),
    .LEN_WIDTH       (LW),
    .MEM_INDEX_WIDTH (MIW),
    .READ_LATENCY    (LAT),
    .AR_DEPTH        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arid_i       (arid_i),
    .araddr_i     (araddr_i),
    .arlen_i      (arlen_i),
    .arvalid_i    (arvalid_i),
    .arready_o    (arready_o),
    .rid_o        (rid_o),
    .rdata_o      (rdata_o),
    .rresp_o      (rresp_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i),
    .load_en_i    (load_en_i),
    .load_index_i (load_index_i),
    .load_data_i  (load_data_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic loadWord(input logic [MIW-1:0] idx, input logic [DW-1:0] data);
    load_en_i    = 1'b1;
    load_index_i = idx;
    load_data_i  = data;
    @(negedge clk);
    load_en_i    = 1'b0;
  endtask

  // Presents one AR at a negedge and returns at the negedge right after its handshake edge.
  task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int waitCycles = 0;
    arid_i    = id;
    araddr_i  = addr;
    arlen_i   = len;
    arvalid_i = 1'b1;
    while (!arready_o && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 100) checkOutput("arHandshakeTimeout", 64'(waitCycles), 64'd0);
    @(negedge clk);
  endtask

  // Collects nBeats against expData/expId/expLast; readyPat gives RREADY per valid cycle.
  task automatic collectBeats(input int nBeats, input logic [15:0] readyPat, input int patLen);
    int   beat    = 0;
    int   patIdx  = 0;
    int   cycles  = 0;
    logic inBurst = 1'b0;
    logic readyNow;
    while (beat < nBeats && cycles < 400) begin
      if (rvalid_o) begin
        readyNow = (patIdx < patLen) ? readyPat[patIdx] : 1'b1;
        patIdx++;
        checkOutput("rdata", 64'(rdata_o), 64'(expData[beat]));
        checkOutput("rid",   64'(rid_o),   64'(expId[beat]));
        checkOutput("rlast", 64'(rlast_o), 64'(expLast[beat]));
        checkOutput("rresp", 64'(rresp_o), 64'd0);
        rready_i = readyNow;
        if (readyNow) begin
          inBurst = !expLast[beat];
          beat++;
        end else begin
          inBurst = 1'b1;
        end
      end else begin
        if (inBurst) checkOutput("rvalidHeld", 64'(rvalid_o), 64'd1);
        rready_i = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("beatCount", 64'(beat), 64'(nBeats));
    checkOutput("rvalidAfterLast", 64'(rvalid_o), 64'd0);
  endtask

  task automatic setWrapExpect(input logic [IW-1:0] id);
    expData[0] = WORD_A; expData[1] = WORD_B; expData[2] = WORD_C; expData[3] = WORD_D;
    for (int i = 0; i < 4; i++) begin
      expId[i]   = id;
      expLast[i] = (i == 3);
    end
  endtask

  initial begin
    int w;
    rst          = 1'b1;
    arid_i       = '0;
    araddr_i     = '0;
    arlen_i      = '0;
    arvalid_i    = 1'b0;
    rready_i     = 1'b1;
    load_en_i    = 1'b0;
    load_index_i = '0;
    load_data_i  = '0;
    repeat (2) @(negedge clk);

    checkOutput("resetArready", 64'(arready_o), 64'd0);
    checkOutput("resetRvalid",  64'(rvalid_o),  64'd0);
    checkOutput("resetRlast",   64'(rlast_o),   64'd0);
    checkOutput("resetRid",     64'(rid_o),     64'd0);
    checkOutput("resetRdata",   64'(rdata_o),   64'd0);
    checkOutput("resetRresp",   64'(rresp_o),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("arreadyAfterReset", 64'(arready_o), 64'd1);

    // Single beat: first RVALID exactly LAT+1 cycles after the handshake.
    loadWord(10'd5, 32'hDEAD_BEEF);
    applyStimulus(4'd3, 32'h14, 8'd0);
    arvalid_i = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      checkOutput("latencyIdle", 64'(rvalid_o), 64'd0);
      @(negedge clk);
    end
    expData[0] = 32'hDEAD_BEEF; expId[0] = 4'd3; expLast[0] = 1'b1;
    collectBeats(1, 16'h0000, 0);

    // Burst wrapping from index 1023 back to 0.
    loadWord(10'd1022, WORD_A);
    loadWord(10'd1023, WORD_B);
    loadWord(10'd0,    WORD_C);
    loadWord(10'd1,    WORD_D);
    applyStimulus(4'd5, 32'hFF8, 8'd3);
    arvalid_i = 1'b0;
    setWrapExpect(4'd5);
    collectBeats(4, 16'h0000, 0);

    // Same burst under RREADY pattern 1,0,0,1,0,1,1.
    applyStimulus(4'd7, 32'hFF8, 8'd3);
    arvalid_i = 1'b0;
    setWrapExpect(4'd7);
    collectBeats(4, 16'h0069, 7);

    // Queue full: request 1 is popped at once, 2 and 3 fill the queue, 4 waits for a pop.
    for (int i = 0; i < 8; i++) begin
      loadWord(MIW'(32 + i), 32'hA000_0000 + DW'(i));
      expData[i] = 32'hA000_0000 + DW'(i);
      expId[i]   = IW'(i / 2 + 1);
      expLast[i] = (i % 2 == 1);
    end
    fork
      begin
        applyStimulus(4'd1, 32'd128, 8'd1);
        applyStimulus(4'd2, 32'd136, 8'd1);
        applyStimulus(4'd3, 32'd144, 8'd1);
        arvalid_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
          checkOutput("arreadyFull", 64'(arready_o), 64'd0);
          @(negedge clk);
        end
        checkOutput("arreadyAfterPop", 64'(arready_o), 64'd1);
        applyStimulus(4'd4, 32'd152, 8'd1);
        arvalid_i = 1'b0;
      end
      begin
        collectBeats(8, 16'h0000, 0);
      end
    join

    // Preload race: write lands on the same edge the first beat is registered.
    loadWord(10'd7, 32'h0000_2222);
    applyStimulus(4'd6, 32'h1C, 8'd0);
    arvalid_i = 1'b0;
    repeat (LAT) @(negedge clk);
    loadWord(10'd7, 32'h0000_1111);
    expData[0] = 32'h0000_2222; expId[0] = 4'd6; expLast[0] = 1'b1;
    collectBeats(1, 16'h0000, 0);
    applyStimulus(4'd6, 32'h1C, 8'd0);
    arvalid_i = 1'b0;
    expData[0] = 32'h0000_1111;
    collectBeats(1, 16'h0000, 0);

    // Asynchronous reset while the second beat of a 4-beat burst is on the bus.
    rready_i = 1'b1;
    applyStimulus(4'd9, 32'hFF8, 8'd3);
    arvalid_i = 1'b0;
    w = 0;
    while (!rvalid_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rstBurstStart", 64'(rvalid_o), 64'd1);
    @(negedge clk);
    checkOutput("rstBeat2Data", 64'(rdata_o), 64'(WORD_B));
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstRvalid",  64'(rvalid_o),  64'd0);
    checkOutput("asyncRstRlast",   64'(rlast_o),   64'd0);
    checkOutput("asyncRstArready", 64'(arready_o), 64'd0);
    checkOutput("asyncRstRdata",   64'(rdata_o),   64'd0);
    repeat (2) @(negedge clk);
    checkOutput("rstHeldRvalid", 64'(rvalid_o), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("arreadyRelease", 64'(arready_o), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("noBeatsAfterAbort", 64'(rvalid_o), 64'd0);
    applyStimulus(4'd2, 32'h14, 8'd0);
    arvalid_i = 1'b0;
    expData[0] = 32'hDEAD_BEEF; expId[0] = 4'd2; expLast[0] = 1'b1;
    collectBeats(1, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
